irq_timer_unit: RTL and testbench
=================================

Name: irq_timer_unit

Overview:
- Machine-mode interrupt source block directly upstream of the exception unit; drives its `interrupt` input.
- Contents: 64-bit mtime/mtimecmp timer, software-interrupt bit (msip), external-interrupt synchronizer, and an enable mask.
- Registers are memory-mapped on a simple word bus from the MEM stage.
- Outputs a registered interrupt request plus the mcause code the trap logic records.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte base of the register window (7 words, offsets 0x00-0x18).
- PRESCALE, 1, clk cycles per mtime increment; legal 1..65535.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- bus_addr  in  32  byte address (word-aligned; bits[1:0] ignored).
- bus_wen  in  1  write strobe, one-cycle.
- bus_ren  in  1  read strobe, one-cycle.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid the cycle after bus_ren.
- ext_irq_in  in  1  asynchronous external interrupt line.
- irq_ack  in  1  exception unit took an interrupt trap this cycle.
- interrupt  out  1  interrupt request to the exception unit (registered).
- irq_cause  out  32  mcause value for the current request; 0 when interrupt=0.

Behaviour:
- Register map (offset): 0x00 msip[0] RW; 0x04 mtimecmp[31:0] RW; 0x08 mtimecmp[63:32] RW; 0x0C mtime[31:0] RW; 0x10 mtime[63:32] RW; 0x14 irq_en[2:0] RW (bit0 soft, bit1 timer, bit2 ext); 0x18 irq_pend[2:0] RO.
- Unused register bits read 0. Addresses outside the window: reads return 0, writes are ignored.
- Reset (rst=0) values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, irq_en=0, prescale counter=0, sync flops=0, interrupt=0, irq_cause=0, bus_rdata=0.
- Prescaler counter: counts 0..PRESCALE-1; mtime increments by 1 on the wrap. mtime wraps modulo 2^64.
- A bus write to either mtime half in the same cycle as an increment: the write wins for the written half; the other half keeps its old value (no carry that cycle).
- Pending bits:
  - ext_p = 2-flop synchronized ext_irq_in (level mode).
  - soft_p = msip.
  - timer_p = (mtime >= mtimecmp), 64-bit unsigned compare, evaluated on current register values.
- Request logic: req = pend & irq_en. Priority ext > soft > timer.
- Cause codes: 32'h8000000B (ext), 32'h80000003 (soft), 32'h80000007 (timer).
- interrupt and irq_cause are registered from req: one-cycle latency from the pending/enable change to the output.
- irq_ack: no effect on level sources; software clears them (write msip=0, raise mtimecmp, deassert the device).
- bus_wen and bus_ren together: the read returns the pre-write value.
- bus_rdata holds its last value when bus_ren=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously); interrupt drops the same instant.

Optional Feature:
- Macro: IRQ_EXT_EDGE_EN.
- Defined:
  - A rising edge on the synchronized ext line sets a sticky ext_p latch.
  - irq_ack with irq_cause=ext clears the latch.
  - An edge arriving in the same cycle as the ack leaves the latch set.
  - A write of 1 to irq_pend[2] also clears the latch; other irq_pend bits stay read-only.
- Undefined: level mode as above; irq_pend is fully read-only.

Decomposition:
- Shared package/header holds:
  - Register offsets (OFF_MSIP … OFF_PEND).
  - Cause constants CAUSE_MEI/MSI/MTI.
  - Enable bit indices.
  - Reset value of mtimecmp.
- One natural sub-module: irq_sync2, a 2-flop synchronizer with async active-low reset. In edge mode it also provides a rising-edge detect output.

Test Plan:
- Reset release, no writes, 1000 cycles -> interrupt=0, irq_cause=0, read 0x0C returns an increasing value, read 0x08 returns FFFFFFFF.
- PRESCALE=1; write mtimecmp={0,0x20}, irq_en=3'b010 -> interrupt rises the cycle after mtime reaches 0x20, irq_cause=80000007. Writing mtimecmp hi=1 drops interrupt one cycle later.
- Set msip=1 and ext_irq_in=1 with irq_en=3'b111 and the timer pending -> irq_cause=8000000B. Dropping ext gives 80000003; clearing msip then gives 80000007.
- Write mtime lo=FFFFFFFF, hi=0 -> next increment reads hi=1, lo=0. Write mtime hi=FFFFFFFF, lo=FFFFFFFF -> wrap to 0, and timer_p stays consistent with the unsigned compare.
- IRQ_EXT_EDGE_EN: 3-cycle ext pulse -> interrupt stays set after the pulse ends; irq_ack clears it. Second edge coinciding with irq_ack -> interrupt stays 1.
- Drop rst mid-count with interrupt=1 -> interrupt=0 and mtime=0 immediately. Read out-of-window address 0xFFFF0040 -> 0; write there -> no register changes.

Source files
------------

// File: rtl/irq_timer_unit_pkg.sv
// ============================================================================
// irq_timer_unit_pkg: register offsets, cause codes and source encoding.
// Rev 1.0
// ============================================================================
`default_nettype none

package irq_timer_unit_pkg;

  localparam logic [4:0] OFF_MSIP        = 5'h00;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] OFF_MTIME_LO    = 5'h0C;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h10;
  localparam logic [4:0] OFF_IRQ_EN      = 5'h14;
  localparam logic [4:0] OFF_PEND        = 5'h18;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  localparam int EN_SOFT  = 0;
  localparam int EN_TIMER = 1;
  localparam int EN_EXT   = 2;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_SOFT  = 2'd1,
    SRC_TIMER = 2'd2,
    SRC_EXT   = 2'd3
  } irq_src_e;

  function automatic logic [31:0] cause_of(irq_src_e src);
    case (src)
      SRC_EXT:   cause_of = CAUSE_MEI;
      SRC_SOFT:  cause_of = CAUSE_MSI;
      SRC_TIMER: cause_of = CAUSE_MTI;
      default:   cause_of = 32'h0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync2.sv
// ============================================================================
// irq_sync2: two-flop synchronizer; rising-edge output when IRQ_EXT_EDGE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
`ifdef IRQ_EXT_EDGE_EN
  ,
  output logic rise_o
`endif
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

`ifdef IRQ_EXT_EDGE_EN
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;
`endif

endmodule

`default_nettype wire

// File: rtl/irq_timer_unit.sv
// ============================================================================
// irq_timer_unit: mtime/mtimecmp timer, msip, ext-irq sync and enable mask.
// IRQ_EXT_EDGE_EN selects a sticky edge-triggered ext source. Rev 1.0
// ============================================================================
`default_nettype none

module irq_timer_unit
  import irq_timer_unit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq_in,
  input  logic        irq_ack,
  output logic        interrupt,
  output logic [31:0] irq_cause
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] ps_q, ps_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [2:0]  en_q, en_d;
  logic        interrupt_q, interrupt_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] w_off;
  logic [4:0]  w_reg;
  logic        w_hit;
  logic        w_wr;
  logic        w_wr_pend;
  logic        w_tick;
  logic        w_ext_sync;
  logic        w_ext_p;
  logic        w_timer_p;
  logic [2:0]  w_pend;
  logic [2:0]  w_req;
  irq_src_e    w_src;
  logic [31:0] w_rd_val;

  // Low address bits are cleared before the subtract so sub-word offsets alias.
  assign w_off     = {bus_addr[31:2], 2'b00} - BASE_ADDR;
  assign w_reg     = w_off[4:0];
  assign w_hit     = (w_off[31:5] == 27'd0) && (w_reg <= OFF_PEND);
  assign w_wr      = bus_wen & w_hit;
  assign w_wr_pend = w_wr && (w_reg == OFF_PEND);

  always_comb begin
    ps_d   = ps_q + 16'd1;
    w_tick = 1'b0;
    if (ps_q == PS_LAST) begin
      ps_d   = 16'd0;
      w_tick = 1'b1;
    end
  end

  // A write to either half replaces the increment for that cycle entirely.
  always_comb begin
    mtime_d = mtime_q + {63'd0, w_tick};
    if (w_wr && (w_reg == OFF_MTIME_LO)) mtime_d = {mtime_q[63:32], bus_wdata};
    if (w_wr && (w_reg == OFF_MTIME_HI)) mtime_d = {bus_wdata, mtime_q[31:0]};
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    en_d       = en_q;
    if (w_wr && (w_reg == OFF_MTIMECMP_LO)) mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
    if (w_wr && (w_reg == OFF_MTIMECMP_HI)) mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
    if (w_wr && (w_reg == OFF_MSIP))        msip_d     = bus_wdata[0];
    if (w_wr && (w_reg == OFF_IRQ_EN))      en_d       = bus_wdata[2:0];
  end

`ifdef IRQ_EXT_EDGE_EN
  logic w_ext_rise;
  logic w_ack_ext;
  logic ext_lat_q, ext_lat_d;
  logic w_unused;

  irq_sync2 u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ext_irq_in),
    .q_o    (w_ext_sync),
    .rise_o (w_ext_rise)
  );

  assign w_ack_ext = irq_ack && (cause_q == CAUSE_MEI);

  // A fresh edge outranks any clear arriving in the same cycle.
  always_comb begin
    ext_lat_d = ext_lat_q;
    if (w_ack_ext || (w_wr_pend && bus_wdata[EN_EXT])) ext_lat_d = 1'b0;
    if (w_ext_rise) ext_lat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_lat_q <= 1'b0;
    end else begin
      ext_lat_q <= ext_lat_d;
    end
  end

  assign w_ext_p  = ext_lat_q;
  assign w_unused = ^{bus_addr[1:0], w_ext_sync};
`else
  logic w_unused;

  irq_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ext_irq_in),
    .q_o (w_ext_sync)
  );

  assign w_ext_p  = w_ext_sync;
  assign w_unused = ^{bus_addr[1:0], irq_ack, w_wr_pend};
`endif

  assign w_timer_p = (mtime_q >= mtimecmp_q);
  assign w_pend    = {w_ext_p, w_timer_p, msip_q};
  assign w_req     = w_pend & en_q;

  always_comb begin
    w_src = SRC_NONE;
    if (w_req[EN_TIMER]) w_src = SRC_TIMER;
    if (w_req[EN_SOFT])  w_src = SRC_SOFT;
    if (w_req[EN_EXT])   w_src = SRC_EXT;
    interrupt_d = (w_src != SRC_NONE);
    cause_d     = cause_of(w_src);
  end

  always_comb begin
    w_rd_val = 32'd0;
    if (w_hit) begin
      case (w_reg)
        OFF_MSIP:        w_rd_val = {31'd0, msip_q};
        OFF_MTIMECMP_LO: w_rd_val = mtimecmp_q[31:0];
        OFF_MTIMECMP_HI: w_rd_val = mtimecmp_q[63:32];
        OFF_MTIME_LO:    w_rd_val = mtime_q[31:0];
        OFF_MTIME_HI:    w_rd_val = mtime_q[63:32];
        OFF_IRQ_EN:      w_rd_val = {29'd0, en_q};
        OFF_PEND:        w_rd_val = {29'd0, w_pend};
        default:         w_rd_val = 32'd0;
      endcase
    end
    rdata_d = bus_ren ? w_rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q        <= 16'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= MTIMECMP_RST;
      msip_q      <= 1'b0;
      en_q        <= 3'b000;
      interrupt_q <= 1'b0;
      cause_q     <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      ps_q        <= ps_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      en_q        <= en_d;
      interrupt_q <= interrupt_d;
      cause_q     <= cause_d;
      rdata_q     <= rdata_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_cause = cause_q;
  assign bus_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_timer_unit.sv
// ============================================================================
// tb_irq_timer_unit: register table plus timer/priority/reset sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_timer_unit;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_addr = 32'd0;
  logic        bus_wen = 1'b0;
  logic        bus_ren = 1'b0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        ext_irq_in = 1'b0;
  logic        irq_ack = 1'b0;
  logic        interrupt;
  logic [31:0] irq_cause;

  irq_timer_unit #(.BASE_ADDR(B), .PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wen    (bus_wen),
    .bus_ren    (bus_ren),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .ext_irq_in (ext_irq_in),
    .irq_ack    (irq_ack),
    .interrupt  (interrupt),
    .irq_cause  (irq_cause)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus_wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] e;
    bus_addr = addr;
    bus_ren  = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus_ren = 1'b0;
    if (exp_q.size() == 0) begin
      e = 32'hDEAD_DEAD;
    end else begin
      e = exp_q.pop_front();
    end
    check(name, bus_rdata, e);
  endtask

  task automatic chk_irq(input string name, input logic exp_int, input logic [31:0] exp_cause);
    check({name, "_int"}, {31'd0, interrupt}, {31'd0, exp_int});
    check({name, "_cause"}, irq_cause, exp_cause);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{B + 32'h00, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, "msip_rw1"};
    tbl[1]  = '{B + 32'h00, 1'b1, 32'h0000_0000, 32'h0000_0000, "msip_rw0"};
    tbl[2]  = '{B + 32'h14, 1'b1, 32'hFFFF_FFFF, 32'h0000_0007, "en_rw"};
    tbl[3]  = '{B + 32'h14, 1'b1, 32'h0000_0000, 32'h0000_0000, "en_clr"};
    tbl[4]  = '{B + 32'h04, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "cmp_lo"};
    tbl[5]  = '{B + 32'h08, 1'b1, 32'h1234_5678, 32'h1234_5678, "cmp_hi"};
    tbl[6]  = '{B + 32'h08, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "cmp_hi_rst"};
    tbl[7]  = '{B + 32'h04, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "cmp_lo_rst"};
    tbl[8]  = '{32'hFFFF_0040, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, "oow_40"};
    tbl[9]  = '{32'hFFFF_001C, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, "oow_1c"};
    tbl[10] = '{32'hFFFF_0003, 1'b1, 32'h0000_0001, 32'h0000_0001, "msip_lowbits"};
    tbl[11] = '{B + 32'h18, 1'b1, 32'h0000_0000, 32'h0000_0001, "pend_soft_ro"};
    tbl[12] = '{B + 32'h00, 1'b1, 32'h0000_0000, 32'h0000_0000, "msip_clr"};
    tbl[13] = '{B + 32'h18, 1'b1, 32'h0000_0007, 32'h0000_0000, "pend_idle"};
    tbl[14] = '{32'hFFFE_0000, 1'b1, 32'h0000_0001, 32'h0000_0000, "oow_below"};

    // Reset state, including a read strobe that must not load data in reset.
    bus_ren = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_ren = 1'b0;
    chk_irq("reset", 1'b0, 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    tick(1000);
    chk_irq("idle1000", 1'b0, 32'd0);
    rd(B + 32'h0C, 32'd1000, "mtime_lo_1000");
    rd(B + 32'h0C, 32'd1001, "mtime_lo_1001");
    rd(B + 32'h08, 32'hFFFF_FFFF, "cmp_hi_reset");

    // Read and write together return the pre-write value.
    bus_addr  = B;
    bus_wdata = 32'd1;
    bus_wen   = 1'b1;
    bus_ren   = 1'b1;
    @(posedge clk);
    #1;
    bus_wen = 1'b0;
    bus_ren = 1'b0;
    check("rw_same_cycle", bus_rdata, 32'd0);
    rd(B, 32'd1, "rw_after");
    tick(2);
    check("rdata_hold", bus_rdata, 32'd1);
    wr(B, 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    rd(B + 32'h14, 32'd0, "oow_no_en_change");
    rd(B + 32'h00, 32'd0, "oow_no_msip_change");

    // Timer threshold: mtime is 0 right after the lo write, +1 per cycle.
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h14, 32'd2);
    wr(B + 32'h04, 32'h20);
    wr(B + 32'h08, 32'd0);
    tick(29);
    chk_irq("timer_before", 1'b0, 32'd0);
    tick(1);
    chk_irq("timer_hit", 1'b1, 32'h8000_0007);
    wr(B + 32'h08, 32'd1);
    chk_irq("timer_drop_lat", 1'b1, 32'h8000_0007);
    tick(1);
    chk_irq("timer_dropped", 1'b0, 32'd0);

    // Priority ext > soft > timer.
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h14, 32'd7);
    wr(B + 32'h00, 32'd1);
    ext_irq_in = 1'b1;
    tick(5);
    chk_irq("prio_ext", 1'b1, 32'h8000_000B);
    ext_irq_in = 1'b0;
`ifdef IRQ_EXT_EDGE_EN
    wr(B + 32'h18, 32'd4);
`endif
    tick(5);
    chk_irq("prio_soft", 1'b1, 32'h8000_0003);
    wr(B + 32'h00, 32'd0);
    tick(2);
    chk_irq("prio_timer", 1'b1, 32'h8000_0007);

    // Carry from lo into hi, then full 64-bit wrap.
    wr(B + 32'h10, 32'd0);
    wr(B + 32'h0C, 32'hFFFF_FFFF);
    tick(1);
    rd(B + 32'h0C, 32'd0, "carry_lo");
    rd(B + 32'h10, 32'd1, "carry_hi");
    wr(B + 32'h10, 32'hFFFF_FFFF);
    wr(B + 32'h0C, 32'hFFFF_FFFF);
    chk_irq("prewrap_timer", 1'b1, 32'h8000_0007);
    tick(1);
    rd(B + 32'h0C, 32'd0, "wrap_lo");
    rd(B + 32'h10, 32'd0, "wrap_hi");
    chk_irq("wrap_timer_clr", 1'b0, 32'd0);

`ifdef IRQ_EXT_EDGE_EN
    wr(B + 32'h14, 32'd4);
    tick(2);
    chk_irq("edge_idle", 1'b0, 32'd0);
    ext_irq_in = 1'b1;
    tick(3);
    ext_irq_in = 1'b0;
    tick(6);
    chk_irq("edge_sticky", 1'b1, 32'h8000_000B);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tick(2);
    chk_irq("edge_ack_clr", 1'b0, 32'd0);
    ext_irq_in = 1'b1;
    tick(3);
    ext_irq_in = 1'b0;
    tick(6);
    chk_irq("edge_rearm", 1'b1, 32'h8000_000B);
    // New edge reaches the latch on the same clock as the ack.
    ext_irq_in = 1'b1;
    tick(2);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tick(4);
    chk_irq("edge_ack_race", 1'b1, 32'h8000_000B);
    ext_irq_in = 1'b0;
    wr(B + 32'h18, 32'd4);
    tick(2);
    chk_irq("edge_pend_clr", 1'b0, 32'd0);
`endif

    // Asynchronous reset while an interrupt is asserted.
    wr(B + 32'h14, 32'd1);
    wr(B + 32'h00, 32'd1);
    tick(2);
    chk_irq("pre_reset", 1'b1, 32'h8000_0003);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_irq("async_reset", 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rd(B + 32'h0C, 32'd0, "reset_mtime");
    rd(B + 32'h00, 32'd0, "reset_msip");
    rd(B + 32'h08, 32'hFFFF_FFFF, "reset_cmp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
